// File: rtl/delta_pkg.sv
// Shared definitions for the delta zero-run-length encoder.
//   state_e        encoder FSM states
//   TOK_LIT/RUN    values driven on out_is_run
//   DEF_W/RUN_W    default data and run-counter widths
package delta_pkg;

  localparam int unsigned DEF_W     = 32;
  localparam int unsigned DEF_RUN_W = 16;

  localparam logic TOK_LIT = 1'b0;
  localparam logic TOK_RUN = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no open run, run_cnt is 0
    S_RUN  = 2'd1,  // counting consecutive zero diffs
    S_PEND = 2'd2   // run token sent, literal that ended it waits in pend_reg
  } state_e;

endpackage

// File: rtl/rle_out_reg.sv
// One-entry valid/ready output register for the RLE encoder.
//   clk, rst        clock, synchronous active-high reset
//   load            capture ld_* this cycle (only asserted when the slot is free)
//   ld_is_run/data/last  token to capture
//   out_ready       downstream accepts the held token
//   out_valid/is_run/data/last  registered token
// Holds its contents while out_valid & !out_ready; a pop and a load in the
// same cycle give back-to-back tokens.
module rle_out_reg
  import delta_pkg::*;
#(
  parameter int unsigned W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         ld_is_run,
  input  logic [W-1:0] ld_data,
  input  logic         ld_last,
  input  logic         out_ready,
  output logic         out_valid,
  output logic         out_is_run,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  logic         valid_q, valid_d;
  logic         is_run_q, is_run_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves a latch.
    valid_d  = valid_q;
    is_run_d = is_run_q;
    data_d   = data_q;
    last_d   = last_q;
    if (load) begin
      valid_d  = 1'b1;
      is_run_d = ld_is_run;
      data_d   = ld_data;
      last_d   = ld_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use <= so every flop samples pre-edge values.
    if (rst) begin
      valid_q  <= 1'b0;
      is_run_q <= TOK_LIT;
      data_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      is_run_q <= is_run_d;
      data_q   <= data_d;
      last_q   <= last_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_is_run = is_run_q;
  assign out_data   = data_q;
  assign out_last   = last_q;

endmodule

// File: rtl/delta_rle_encoder.sv
// Zero-run-length encoder for a signed difference stream.
//   clk, rst       clock, synchronous active-high reset
//   in_valid/in_ready/in_diff/in_last   input stream (two's complement diffs)
//   out_valid/out_ready/out_is_run/out_data/out_last   registered token stream
// Runs of zero diffs become RUN(count) tokens (split at MAX_RUN); each nonzero
// diff becomes a LITERAL token carrying the diff bit-exact. in_last closes any
// open run and marks the frame's final token.
module delta_rle_encoder
  import delta_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned RUN_W   = DEF_RUN_W,
  parameter int unsigned MAX_RUN = 2**RUN_W - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_diff,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_is_run,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  localparam logic [RUN_W:0] MAX_RUN_C = (RUN_W+1)'(MAX_RUN);

  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [W-1:0]     pend_data_q, pend_data_d;
  logic             pend_last_q, pend_last_d;

  logic             slot_free, acc, diff_zero;
  logic [RUN_W:0]   run_inc;   // one bit wider so the MAX_RUN compare cannot wrap
  logic             load, ld_is_run, ld_last;
  logic [W-1:0]     ld_data;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = (state_q != S_PEND) && slot_free;
  assign acc       = in_valid && in_ready;
  assign diff_zero = (in_diff == '0);
  assign run_inc   = {1'b0, run_cnt_q} + (RUN_W+1)'(1);

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    pend_data_d = pend_data_q;
    pend_last_d = pend_last_q;
    load        = 1'b0;
    ld_is_run   = TOK_LIT;
    ld_data     = in_diff;
    ld_last     = in_last;

    unique case (state_q)
      S_IDLE: begin
        if (acc) begin
          if (!diff_zero) begin
            load = 1'b1;
          end else if (in_last) begin
            load      = 1'b1;
            ld_is_run = TOK_RUN;
            ld_data   = W'(1);
          end else begin
            run_cnt_d = RUN_W'(1);
            state_d   = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (acc) begin
          if (diff_zero && (run_inc == MAX_RUN_C || in_last)) begin
            load      = 1'b1;
            ld_is_run = TOK_RUN;
            ld_data   = W'(run_inc);
            run_cnt_d = '0;
            state_d   = S_IDLE;
          end else if (diff_zero) begin
            run_cnt_d = run_inc[RUN_W-1:0];
          end else begin
            // The run is closed first; the literal that broke it waits one
            // slot so both tokens keep input order.
            load        = 1'b1;
            ld_is_run   = TOK_RUN;
            ld_data     = W'(run_cnt_q);
            ld_last     = 1'b0;
            pend_data_d = in_diff;
            pend_last_d = in_last;
            run_cnt_d   = '0;
            state_d     = S_PEND;
          end
        end
      end

      S_PEND: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_data = pend_data_q;
          ld_last = pend_last_q;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      run_cnt_q   <= '0;
      // NOTE: pend_reg is only read in S_PEND, which reset leaves, so clearing
      // it is not needed for correctness; it is cleared to keep dumps tidy.
      pend_data_q <= '0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      pend_data_q <= pend_data_d;
      pend_last_q <= pend_last_d;
    end
  end

  rle_out_reg #(.W(W)) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .ld_is_run  (ld_is_run),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_is_run (out_is_run),
    .out_data   (out_data),
    .out_last   (out_last)
  );

endmodule
